// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans an 8-column x 4-row active-low key matrix one column at a time.
// Each column is driven low for SETTLE_CYCLES cycles, and then its rows are
// sampled into a frame buffer. After column 7 the frame is committed to
// `keys` and `scan_done` pulses.
// Optional feature: define GHOST_REJECT_EN to reject ghosted frames. A frame
// is ghosted when two columns share two or more pressed rows. A rejected
// frame leaves `keys` unchanged and raises `ghost`.
module keypad_matrix_scanner #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_sense,
  output logic [7:0]  col_drive,
  output logic [31:0] keys,
  output logic        scan_done,
  output logic        ghost
);

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    COMMIT
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  col, col_next;
  logic [7:0]  count, count_next;
  logic [31:0] frame, frame_next;
  logic [31:0] keys_next;
  logic [7:0]  col_drive_next;
  logic        scan_done_next;
  logic [3:0]  row_meta, row_sync;

`ifdef GHOST_REJECT_EN
  logic ghost_q, ghost_next;

  // True when any two distinct columns share at least two pressed rows
  function automatic logic frame_ghosted(input logic [31:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      for (int unsigned j = i + 1; j < 8; j++) begin
        if ($countones(f[i*4 +: 4] & f[j*4 +: 4]) >= 2) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction
`endif

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_sense;
      row_sync <= row_meta;
    end
  end

  // Scan state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SETTLE;
      col       <= '0;
      count     <= '0;
      frame     <= '0;
      keys      <= '0;
      col_drive <= '1;
      scan_done <= 1'b0;
`ifdef GHOST_REJECT_EN
      ghost_q   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      col       <= col_next;
      count     <= count_next;
      frame     <= frame_next;
      keys      <= keys_next;
      col_drive <= col_drive_next;
      scan_done <= scan_done_next;
`ifdef GHOST_REJECT_EN
      ghost_q   <= ghost_next;
`endif
    end
  end

  // Next-state logic: settle count, row sampling, and frame commit.
  // col_drive is computed from the next state so the registered pin already
  // shows the new column in the first cycle of that column's settle window.
  always_comb begin
    state_next     = state;
    col_next       = col;
    count_next     = count;
    frame_next     = frame;
    keys_next      = keys;
    scan_done_next = 1'b0;
`ifdef GHOST_REJECT_EN
    ghost_next     = ghost_q;
`endif

    case (state)
      SETTLE: begin
        if (count == LAST_COUNT) begin
          state_next = SAMPLE;
        end else begin
          count_next = count + 8'd1;
        end
      end

      SAMPLE: begin
        frame_next[{col, 2'b00} +: 4] = ~row_sync;
        if (col == 3'd7) begin
          state_next = COMMIT;
        end else begin
          col_next   = col + 3'd1;
          count_next = '0;
          state_next = SETTLE;
        end
      end

      COMMIT: begin
`ifdef GHOST_REJECT_EN
        if (frame_ghosted(frame)) begin
          ghost_next = 1'b1;
        end else begin
          keys_next  = frame;
          ghost_next = 1'b0;
        end
`else
        keys_next      = frame;
`endif
        scan_done_next = 1'b1;
        col_next       = '0;
        count_next     = '0;
        state_next     = SETTLE;
      end

      default: begin
        state_next = SETTLE;
        col_next   = '0;
        count_next = '0;
      end
    endcase

    if (state_next == COMMIT) begin
      col_drive_next = '1;
    end else begin
      col_drive_next = ~(8'd1 << col_next);
    end
  end

`ifdef GHOST_REJECT_EN
  assign ghost = ghost_q;
`else
  assign ghost = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Testbench for keypad_matrix_scanner.
// A key set drives the rows combinationally from the active column.
// Expected outputs come from cycle-position arithmetic on the frame period,
// and from the key set that was held during each frame.
module tb_keypad_matrix_scanner;

  localparam int unsigned SC  = 16;
  localparam int unsigned SC3 = 3;
  localparam int unsigned P   = 8 * (SC + 1) + 1;
  localparam int unsigned P3  = 8 * (SC3 + 1) + 1;
  localparam logic [31:0] K3  = 32'h0010_0000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_sense, row_sense3;
  logic [7:0]  col_drive, col_drive3;
  logic [31:0] keys, keys3;
  logic        scan_done, scan_done3;
  logic        ghost, ghost3;

  logic [31:0] pressed;
  logic [31:0] active_set;
  logic [31:0] exp_keys;
  logic        exp_ghost;
  logic [31:0] pressed3;
  int unsigned n;
  int          tests;
  int          failed;

  keypad_matrix_scanner dut (
    .clk(clk), .rst_n(rst_n), .row_sense(row_sense), .col_drive(col_drive),
    .keys(keys), .scan_done(scan_done), .ghost(ghost)
  );

  keypad_matrix_scanner #(.SETTLE_CYCLES(SC3)) dut3 (
    .clk(clk), .rst_n(rst_n), .row_sense(row_sense3), .col_drive(col_drive3),
    .keys(keys3), .scan_done(scan_done3), .ghost(ghost3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_sense = 4'hF;
    for (int c = 0; c < 8; c++) begin
      if (col_drive[c] == 1'b0) row_sense = row_sense & ~pressed[c*4 +: 4];
    end
  end

  always_comb begin
    row_sense3 = 4'hF;
    for (int c = 0; c < 8; c++) begin
      if (col_drive3[c] == 1'b0) row_sense3 = row_sense3 & ~pressed3[c*4 +: 4];
    end
  end

  function automatic logic [7:0] exp_cd(input int unsigned cyc, input int unsigned sc);
    int unsigned per, m;
    per = 8 * (sc + 1) + 1;
    m = cyc % per;
    if (m == per - 1) return 8'hFF;
    return ~(8'd1 << (m / (sc + 1)));
  endfunction

  function automatic bit is_ghost(input logic [31:0] s);
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        int shared;
        shared = 0;
        for (int r = 0; r < 4; r++) begin
          if (s[i*4 + r] && s[j*4 + r]) shared++;
        end
        if (shared >= 2) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: advance the position model and compare all outputs of both instances
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (n % P == 0) begin
`ifdef GHOST_REJECT_EN
      if (is_ghost(active_set)) begin
        exp_ghost = 1'b1;
      end else begin
        exp_keys  = active_set;
        exp_ghost = 1'b0;
      end
`else
      exp_keys = active_set;
`endif
    end
    check("col_drive", {24'd0, col_drive}, {24'd0, exp_cd(n, SC)});
    check("scan_done", {31'd0, scan_done}, {31'd0, (n % P == 0)});
    check("keys", keys, exp_keys);
    check("ghost", {31'd0, ghost}, {31'd0, exp_ghost});
    check("col_drive3", {24'd0, col_drive3}, {24'd0, exp_cd(n, SC3)});
    check("scan_done3", {31'd0, scan_done3}, {31'd0, (n % P3 == 0)});
    check("keys3", keys3, (n >= P3) ? K3 : 32'd0);
  endtask

  task automatic run_frame();
    do step(); while (n % P != 0);
  endtask

  task automatic set_keys(input logic [31:0] v);
    pressed    = v;
    active_set = v;
  endtask

  task automatic check_reset_values();
    check("rst_col_drive", {24'd0, col_drive}, 32'h0000_00FF);
    check("rst_keys", keys, 32'd0);
    check("rst_scan_done", {31'd0, scan_done}, 32'd0);
    check("rst_ghost", {31'd0, ghost}, 32'd0);
    check("rst_col_drive3", {24'd0, col_drive3}, 32'h0000_00FF);
    check("rst_keys3", keys3, 32'd0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    n = 0;
    exp_keys = '0;
    exp_ghost = 1'b0;
    pressed3 = K3;
    set_keys('0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle rows: two full frames
    run_frame();
    run_frame();

    // Single key col 2 row 1, then release
    set_keys(32'h0000_0200);
    run_frame();
    check("single_key", keys, 32'h0000_0200);
    set_keys('0);
    run_frame();
    check("release", keys, 32'd0);

    // Three keys in distinct rows and columns
    set_keys(32'h8000_4001);
    run_frame();
    check("multi_key", keys, 32'h8000_4001);
    check("multi_ghost", {31'd0, ghost}, 32'd0);

`ifdef GHOST_REJECT_EN
    set_keys(32'h0000_0001);
    run_frame();
    set_keys(32'h0000_0033);
    run_frame();
    check("ghost_hold_keys", keys, 32'h0000_0001);
    check("ghost_flag", {31'd0, ghost}, 32'd1);
    set_keys(32'h0000_0001);
    run_frame();
    check("ghost_clear_keys", keys, 32'h0000_0001);
    check("ghost_clear_flag", {31'd0, ghost}, 32'd0);
`endif

    // Random sparse key sets, one per frame
    for (int k = 0; k < 6; k++) begin
      set_keys($urandom & $urandom & $urandom);
      run_frame();
    end

    // Asynchronous reset while column 4 is being scanned
    set_keys(32'h0010_1100);
    do step(); while (((n % P) / (SC + 1)) != 4);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    exp_keys = '0;
    exp_ghost = 1'b0;
    run_frame();
    check("post_reset_frame", keys, 32'h0010_1100);
    check("post_reset_cycles", n, P);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles a column is driven before its rows are sampled; legal range 3..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port row_sense, input, 4 bits: matrix rows, active-low, externally pulled up, asynchronous to clk.
REQ-005 SHALL have port col_drive, output, 8 bits: matrix columns, active-low, at most one bit low at any time, registered.
REQ-006 SHALL have port keys, output, 32 bits: committed key state, 1 = pressed; bit index col*4+row; registered; feeds input_debounce.inputs.
REQ-007 SHALL have port scan_done, output, 1 bit: one-cycle pulse, high in the cycle keys takes a new frame result.
REQ-008 SHALL have port ghost, output, 1 bit: last frame rejected as ghosted; registered.

Function
REQ-009 SHALL pass row_sense through a 2-flop synchronizer (row_sync) before any use.
REQ-010 SHALL hold a 3-bit column index col, an 8-bit settle counter, a 32-bit frame buffer and a state in {SETTLE, SAMPLE, COMMIT}.
REQ-011 SETTLE: col_drive = ~(1<<col); counter increments from 0; at counter == SETTLE_CYCLES-1 SHALL go to SAMPLE.
REQ-012 SAMPLE (one cycle): col_drive unchanged; frame[col*4+3:col*4] <= ~row_sync; if col == 7 SHALL go to COMMIT, else col <= col+1, counter <= 0, go to SETTLE.
REQ-013 COMMIT (one cycle): col_drive = 8'hFF; keys <= frame (subject to REQ-019); scan_done high the following cycle together with the new keys value; col <= 0, counter <= 0, go to SETTLE.
REQ-014 Column-to-sample latency SHALL be exactly SETTLE_CYCLES cycles; frame period SHALL be 8*(SETTLE_CYCLES+1)+1 cycles (137 at default).
REQ-015 keys SHALL change only on scan_done cycles; a key pressed or released mid-frame appears in the current frame only if its column is sampled after the change reaches row_sync, otherwise in the next frame.
REQ-016 Multiple simultaneous presses in distinct rows/columns SHALL all be reported in the same frame.
REQ-017 Counter SHALL never wrap; col wraps 7 -> 0 only via COMMIT.

Reset
REQ-018 While rst_n low: col_drive 8'hFF, keys 0, scan_done 0, ghost 0, frame 0, row_sync 4'hF, col 0, counter 0, state SETTLE; reset asserted mid-frame SHALL discard the partial frame; first edge after release drives col_drive 8'hFE and starts counting.

Configuration
REQ-019 With GHOST_REJECT_EN defined: at COMMIT, if any two columns i != j share two or more pressed rows (popcount(frame_col_i & frame_col_j) >= 2), keys SHALL hold its previous value and ghost <= 1; otherwise keys <= frame and ghost <= 0; scan_done pulses in both cases.
REQ-020 Without GHOST_REJECT_EN: keys <= frame on every COMMIT, ghost tied 0, no pair-compare logic synthesized.

Verification
REQ-021 Reset, rows idle 4'hF, run 2 frames -> col_drive cycles FE,FD,...,7F then FF for 1 cycle; keys 0; scan_done every 137 cycles.
REQ-022 Hold key col 2 row 1 (row_sense bit1 low only while col_drive == FB) -> after next scan_done keys == 32'h0000_0200; release -> keys == 0 one frame later.
REQ-023 Keys (0,0),(3,2),(7,3) pressed -> keys == 32'h8000_4001 in one frame, ghost 0.
REQ-024 GHOST_REJECT_EN: prior keys 32'h1; press (0,0),(0,1),(1,0),(1,1) -> keys stays 32'h1, ghost 1, scan_done pulses; release to (0,0) only -> keys 32'h1, ghost 0.
REQ-025 Assert rst_n low while col == 4 with keys pressed -> all outputs to reset values immediately (asynchronous); after release first scan_done occurs 137 cycles later with a complete frame.
REQ-026 SETTLE_CYCLES = 3 -> frame period 33 cycles, key (5,0) reported as 32'h0010_0000.
